// File: rtl/rv_decode_pkg.sv
// Shared encodings for the RV32 decode stage: opcodes, control field codes
// and the packed control bundle carried through the stage.
package rv_decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_CSR = 2'b11;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SB   = 2'b11;

  localparam logic [2:0] RW_NONE = 3'b000;
  localparam logic [2:0] RW_WORD = 3'b001;
  localparam logic [2:0] RW_LB   = 3'b010;
  localparam logic [2:0] RW_LH   = 3'b011;
  localparam logic [2:0] RW_LBU  = 3'b100;
  localparam logic [2:0] RW_LHU  = 3'b101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LUI   = 2'b11;

  localparam logic [1:0] CSR_WRITE = 2'b00;
  localparam logic [1:0] CSR_SET   = 2'b01;
  localparam logic [1:0] CSR_CLEAR = 2'b10;

  typedef struct packed {
    logic [2:0] reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [1:0] mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
    logic       auipc;
    logic       muldiv;
    logic       csr_rd;
    logic       csr_wr;
    logic [1:0] csr_wd_sel;
    logic       rs1_imm_sel;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/rv_ctrl_decode.sv
// Combinational RV32 control decoder: instruction word -> control bundle.
// Any unsupported encoding collapses to a bundle with only illegal set.
module rv_ctrl_decode
  import rv_decode_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic       unused_rs2;
  ctrl_t      c;
  logic       bad;

  assign op         = instr[6:0];
  assign rd         = instr[11:7];
  assign f3         = instr[14:12];
  assign rs1        = instr[19:15];
  assign f7         = instr[31:25];
  assign unused_rs2 = ^instr[24:20];
  assign ctrl       = c;

  // Decode opcode/funct fields into controls, then squash on illegal encodings
  always_comb begin
    c   = '0;
    bad = 1'b0;
    case (op)
      OP_LOAD: begin
        c.imm_src    = IMM_I;
        c.alu_src    = 1'b1;
        c.result_src = RES_MEM;
        c.alu_op     = ALU_ADD;
        case (f3)
          3'b010:  c.reg_write = RW_WORD;
          3'b000:  c.reg_write = RW_LB;
          3'b001:  c.reg_write = RW_LH;
          3'b100:  c.reg_write = RW_LBU;
          3'b101:  c.reg_write = RW_LHU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        c.imm_src = IMM_S;
        c.alu_src = 1'b1;
        c.alu_op  = ALU_ADD;
        case (f3)
          3'b010:  c.mem_write = MW_SW;
          3'b001:  c.mem_write = MW_SH;
          3'b000:  c.mem_write = MW_SB;
          default: bad = 1'b1;
        endcase
      end
      OP_OP: begin
        c.reg_write = RW_WORD;
        c.alu_op    = ALU_FUNCT;
        if (f7 == 7'b0000000) begin
          bad = 1'b0;
        end else if (f7 == 7'b0100000) begin
          // only sub and sra carry the alternate funct7
          bad = !((f3 == 3'b000) || (f3 == 3'b101));
        end else if ((f7 == 7'b0000001) && ENABLE_M) begin
          c.muldiv = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OP_IMM: begin
        c.reg_write = RW_WORD;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_FUNCT;
        c.imm_src   = IMM_I;
        // funct7 is immediate data except for the shift-immediate forms
        if (f3 == 3'b001) begin
          c.imm_src = IMM_SHAMT;
          bad       = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          c.imm_src = IMM_SHAMT;
          bad       = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
        end
      end
      OP_BRANCH: begin
        c.branch  = 1'b1;
        c.imm_src = IMM_B;
        c.alu_op  = ALU_BR;
      end
      OP_JAL: begin
        c.jump       = 1'b1;
        c.reg_write  = RW_WORD;
        c.imm_src    = IMM_J;
        c.result_src = RES_PC4;
      end
      OP_JALR: begin
        c.jalr       = 1'b1;
        c.reg_write  = RW_WORD;
        c.imm_src    = IMM_I;
        c.alu_src    = 1'b1;
        c.result_src = RES_PC4;
        c.alu_op     = ALU_ADD;
      end
      OP_LUI: begin
        c.reg_write = RW_WORD;
        c.imm_src   = IMM_U;
        c.alu_src   = 1'b1;
        c.alu_op    = ALU_LUI;
      end
      OP_AUIPC: begin
        c.reg_write = RW_WORD;
        c.imm_src   = IMM_U;
        c.alu_src   = 1'b1;
        c.auipc     = 1'b1;
        c.alu_op    = ALU_ADD;
      end
      OP_SYSTEM: begin
        // funct3 000 is ECALL/EBREAK: legal, no datapath effect
        if (f3 != 3'b000) begin
          if (!ENABLE_CSR || (f3 == 3'b100)) begin
            bad = 1'b1;
          end else begin
            c.result_src  = RES_CSR;
            c.csr_rd      = !((f3[1:0] == 2'b01) && (rd == 5'd0));
            c.csr_wr      = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
            c.rs1_imm_sel = f3[2];
            c.imm_src     = f3[2] ? IMM_ZIMM : IMM_I;
            c.reg_write   = c.csr_rd ? RW_WORD : RW_NONE;
            case (f3[1:0])
              2'b01:   c.csr_wd_sel = CSR_WRITE;
              2'b10:   c.csr_wd_sel = CSR_SET;
              default: c.csr_wd_sel = CSR_CLEAR;
            endcase
          end
        end
      end
      OP_FENCE: begin
        bad = 1'b0;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c         = '0;
      c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Registered RV32 decode stage with valid/ready handshake, a one-entry
// skid buffer behind the output head register, and flush.
module decode_stage_pipe
  import rv_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      reg_write,
  output logic [2:0]      imm_src,
  output logic            alu_src,
  output logic [1:0]      mem_write,
  output logic [1:0]      result_src,
  output logic            branch,
  output logic [1:0]      alu_op,
  output logic            jump,
  output logic            jalr,
  output logic            auipc,
  output logic            muldiv,
  output logic            csr_rd,
  output logic            csr_wr,
  output logic [1:0]      csr_wd_sel,
  output logic            rs1_imm_sel,
  output logic            illegal
);

  // ---- stage p0: combinational decode of the incoming word ----
  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec_p0;

  rv_ctrl_decode #(
    .ENABLE_M   (ENABLE_M),
    .ENABLE_CSR (ENABLE_CSR)
  ) u_dec (
    .instr (instr_in),
    .ctrl  (dec_bits)
  );

  assign dec_p0 = dec_bits;

  // ---- stage p1: head register and skid entry ----
  logic            vld_p1;
  logic            skid_vld_p1;
  ctrl_t           hd_ctrl_p1;
  ctrl_t           skid_ctrl_p1;
  logic [31:0]     hd_instr_p1;
  logic [31:0]     skid_instr_p1;
  logic [XLEN-1:0] hd_pc_p1;
  logic [XLEN-1:0] skid_pc_p1;

  logic accept;
  logic drain;
  logic hd_load;
  logic skid_load;

  // in_ready depends only on held state, never on out_ready
  assign in_ready  = !rst && !skid_vld_p1;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = vld_p1 && out_ready;
  assign hd_load   = drain || !vld_p1;
  assign skid_load = vld_p1 && !out_ready && !skid_vld_p1;

  // Valid bits: flush and reset empty the stage; skid refills head on drain
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (drain) begin
      vld_p1      <= skid_vld_p1 || accept;
      skid_vld_p1 <= 1'b0;
    end else if (!vld_p1) begin
      vld_p1      <= accept;
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // Head data: older skid entry has priority over the incoming word
  always_ff @(posedge clk) begin
    if (hd_load) begin
      if (skid_vld_p1) begin
        hd_ctrl_p1  <= skid_ctrl_p1;
        hd_instr_p1 <= skid_instr_p1;
        hd_pc_p1    <= skid_pc_p1;
      end else begin
        hd_ctrl_p1  <= dec_p0;
        hd_instr_p1 <= instr_in;
        hd_pc_p1    <= pc_in;
      end
    end
  end

  // Skid data: captures the incoming word while the head is stalled
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_ctrl_p1  <= dec_p0;
      skid_instr_p1 <= instr_in;
      skid_pc_p1    <= pc_in;
    end
  end

  // ---- outputs: zeroed whenever the head is empty ----
  ctrl_t out_c;

  assign out_valid   = vld_p1;
  assign out_c       = vld_p1 ? hd_ctrl_p1 : '0;
  assign instr_out   = vld_p1 ? hd_instr_p1 : '0;
  assign pc_out      = vld_p1 ? hd_pc_p1 : '0;
  assign reg_write   = out_c.reg_write;
  assign imm_src     = out_c.imm_src;
  assign alu_src     = out_c.alu_src;
  assign mem_write   = out_c.mem_write;
  assign result_src  = out_c.result_src;
  assign branch      = out_c.branch;
  assign alu_op      = out_c.alu_op;
  assign jump        = out_c.jump;
  assign jalr        = out_c.jalr;
  assign auipc       = out_c.auipc;
  assign muldiv      = out_c.muldiv;
  assign csr_rd      = out_c.csr_rd;
  assign csr_wr      = out_c.csr_wr;
  assign csr_wd_sel  = out_c.csr_wd_sel;
  assign rs1_imm_sel = out_c.rs1_imm_sel;
  assign illegal     = out_c.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: directed vector table, hand-written
// stall/flush sequences, then random traffic against a queue model.
module tb_decode_stage_pipe;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [2:0] reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic [1:0] mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jalr;
    logic       auipc;
    logic       muldiv;
    logic       csr_rd;
    logic       csr_wr;
    logic [1:0] csr_wd_sel;
    logic       rs1_imm_sel;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    bit          nom;
    ctl_t        exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] instr_in;
  logic [XLEN-1:0] pc_in;

  logic a_in_ready, a_out_valid;
  logic [31:0] a_instr_out;
  logic [XLEN-1:0] a_pc_out;
  logic [2:0] a_rw, a_imm;
  logic a_asrc, a_br, a_j, a_jr, a_au, a_md, a_crd, a_cwr, a_ris, a_ill;
  logic [1:0] a_mw, a_rs, a_aop, a_ws;

  logic n_in_ready, n_out_valid;
  logic [31:0] n_instr_out;
  logic [XLEN-1:0] n_pc_out;
  logic [2:0] n_rw, n_imm;
  logic n_asrc, n_br, n_j, n_jr, n_au, n_md, n_crd, n_cwr, n_ris, n_ill;
  logic [1:0] n_mw, n_rs, n_aop, n_ws;

  ctl_t a_ctl, n_ctl;
  assign a_ctl = {a_rw, a_imm, a_asrc, a_mw, a_rs, a_br, a_aop, a_j, a_jr, a_au, a_md, a_crd, a_cwr, a_ws, a_ris, a_ill};
  assign n_ctl = {n_rw, n_imm, n_asrc, n_mw, n_rs, n_br, n_aop, n_j, n_jr, n_au, n_md, n_crd, n_cwr, n_ws, n_ris, n_ill};

  always #5 clk = ~clk;

  decode_stage_pipe #(.XLEN(XLEN), .ENABLE_M(1'b1), .ENABLE_CSR(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .instr_out(a_instr_out), .pc_out(a_pc_out), .reg_write(a_rw), .imm_src(a_imm),
    .alu_src(a_asrc), .mem_write(a_mw), .result_src(a_rs), .branch(a_br), .alu_op(a_aop),
    .jump(a_j), .jalr(a_jr), .auipc(a_au), .muldiv(a_md), .csr_rd(a_crd), .csr_wr(a_cwr),
    .csr_wd_sel(a_ws), .rs1_imm_sel(a_ris), .illegal(a_ill));

  decode_stage_pipe #(.XLEN(XLEN), .ENABLE_M(1'b0), .ENABLE_CSR(1'b0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .out_valid(n_out_valid), .out_ready(out_ready),
    .instr_out(n_instr_out), .pc_out(n_pc_out), .reg_write(n_rw), .imm_src(n_imm),
    .alu_src(n_asrc), .mem_write(n_mw), .result_src(n_rs), .branch(n_br), .alu_op(n_aop),
    .jump(n_j), .jalr(n_jr), .auipc(n_au), .muldiv(n_md), .csr_rd(n_crd), .csr_wr(n_cwr),
    .csr_wd_sel(n_ws), .rs1_imm_sel(n_ris), .illegal(n_ill));

  int n_cmp = 0;
  int n_bad = 0;
  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic ctl_t mk(input logic [2:0] rw, imm, input logic as,
                              input logic [1:0] mw, rs, input logic br,
                              input logic [1:0] aop, input logic j, jr, au, md, cr, cw,
                              input logic [1:0] ws, input logic ris, ill);
    return {rw, imm, as, mw, rs, br, aop, j, jr, au, md, cr, cw, ws, ris, ill};
  endfunction

  // Reference decode written straight from the instruction-set rules
  function automatic ctl_t ref_ctl(input logic [31:0] w, input bit en_m, input bit en_csr);
    ctl_t c = '0;
    bit ok = 1'b1;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    case (w[6:0])
      7'h03: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        c.alu_src = 1; c.result_src = 2'd1;
        c.reg_write = (f3 == 3'd2) ? 3'd1 : (f3 == 3'd0) ? 3'd2 : (f3 == 3'd1) ? 3'd3 :
                      (f3 == 3'd4) ? 3'd4 : 3'd5;
      end
      7'h23: begin
        ok = f3 inside {3'd0, 3'd1, 3'd2};
        c.alu_src = 1; c.imm_src = 3'd1;
        c.mem_write = (f3 == 3'd2) ? 2'd1 : (f3 == 3'd1) ? 2'd2 : 2'd3;
      end
      7'h33: begin
        c.reg_write = 3'd1; c.alu_op = 2'd2;
        if (f7 == 7'h00) ok = 1;
        else if (f7 == 7'h20) ok = (f3 == 3'd0) || (f3 == 3'd5);
        else if (f7 == 7'h01) begin ok = en_m; c.muldiv = 1; end
        else ok = 0;
      end
      7'h13: begin
        c.reg_write = 3'd1; c.alu_src = 1; c.alu_op = 2'd2;
        if (f3 == 3'd1) begin c.imm_src = 3'd5; ok = (f7 == 7'h00); end
        if (f3 == 3'd5) begin c.imm_src = 3'd5; ok = (f7 == 7'h00) || (f7 == 7'h20); end
      end
      7'h63: begin c.branch = 1; c.imm_src = 3'd2; c.alu_op = 2'd1; end
      7'h6f: begin c.jump = 1; c.reg_write = 3'd1; c.imm_src = 3'd3; c.result_src = 2'd2; end
      7'h67: begin c.jalr = 1; c.reg_write = 3'd1; c.alu_src = 1; c.result_src = 2'd2; end
      7'h37: begin c.reg_write = 3'd1; c.imm_src = 3'd4; c.alu_src = 1; c.alu_op = 2'd3; end
      7'h17: begin c.reg_write = 3'd1; c.imm_src = 3'd4; c.alu_src = 1; c.auipc = 1; end
      7'h73: begin
        if (f3 != 3'd0) begin
          ok = en_csr && (f3 != 3'd4);
          c.result_src  = 2'd3;
          c.csr_rd      = !((f3[1:0] == 2'd1) && (w[11:7] == 5'd0));
          c.csr_wr      = (f3[1:0] == 2'd1) || (w[19:15] != 5'd0);
          c.csr_wd_sel  = f3[1:0] - 2'd1;
          c.rs1_imm_sel = f3[2];
          c.imm_src     = f3[2] ? 3'd6 : 3'd0;
          c.reg_write   = c.csr_rd ? 3'd1 : 3'd0;
        end
      end
      7'h0f: ok = 1;
      default: ok = 0;
    endcase
    if (!ok) begin
      c = '0;
      c.illegal = 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] ops[11] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0f};
    int r;
    w = $urandom;
    r = $urandom_range(0, 12);
    if (r < 11) w[6:0] = ops[r];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
    return w;
  endfunction

  // Compare both instances with the queue model at a quiet point of the cycle
  task automatic check_model();
    chk("rnd_out_valid", a_out_valid, q.size() > 0);
    chk("rnd_in_ready", a_in_ready, !rst && (q.size() < 2));
    chk("rnd_n_out_valid", n_out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("rnd_instr_out", a_instr_out, q[0].instr);
      chk("rnd_pc_out", a_pc_out, q[0].pc);
      chk("rnd_ctl", a_ctl, ref_ctl(q[0].instr, 1'b1, 1'b1));
      chk("rnd_n_ctl", n_ctl, ref_ctl(q[0].instr, 1'b0, 1'b0));
    end
  endtask

  vec_t tv[$];
  ctl_t ILL;

  initial begin
    ILL = '0;
    ILL.illegal = 1'b1;
    tv.push_back('{"addi",     32'h00A00093, 1'b0, mk(1,0,1,0,0,0,2,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"lb",       32'h00008103, 1'b0, mk(2,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"ld_f3_011",32'h0000B103, 1'b0, ILL});
    tv.push_back('{"csrrw",    32'h34029073, 1'b0, mk(0,0,0,0,3,0,0,0,0,0,0,0,1,0,0,0)});
    tv.push_back('{"csrrw_noc",32'h34029073, 1'b1, ILL});
    tv.push_back('{"mul",      32'h02208033, 1'b0, mk(1,0,0,0,0,0,2,0,0,0,1,0,0,0,0,0)});
    tv.push_back('{"mul_nom",  32'h02208033, 1'b1, ILL});
    tv.push_back('{"sw",       32'h0020A023, 1'b0, mk(0,1,1,1,0,0,0,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"jal",      32'h008000EF, 1'b0, mk(1,3,0,0,2,0,0,1,0,0,0,0,0,0,0,0)});
    tv.push_back('{"jalr",     32'h000080E7, 1'b0, mk(1,0,1,0,2,0,0,0,1,0,0,0,0,0,0,0)});
    tv.push_back('{"auipc",    32'h00000097, 1'b0, mk(1,4,1,0,0,0,0,0,0,1,0,0,0,0,0,0)});
    tv.push_back('{"lui",      32'h000000B7, 1'b0, mk(1,4,1,0,0,0,3,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"beq",      32'h00208463, 1'b0, mk(0,2,0,0,0,1,1,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"ecall",    32'h00000073, 1'b0, '0});
    tv.push_back('{"fence",    32'h0FF0000F, 1'b0, '0});
    tv.push_back('{"srai",     32'h4020D093, 1'b0, mk(1,5,1,0,0,0,2,0,0,0,0,0,0,0,0,0)});
    tv.push_back('{"csrrsi",   32'h3002E0F3, 1'b0, mk(1,6,0,0,3,0,0,0,0,0,0,1,1,1,1,0)});
    tv.push_back('{"low_bits", 32'h00A00091, 1'b0, ILL});

    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    instr_in = 32'h00A00093; pc_in = 32'h40;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b0);
    chk("rst_instr_out", a_instr_out, 32'h0);
    chk("rst_pc_out", a_pc_out, 32'h0);
    chk("rst_ctl", a_ctl, 24'h0);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1'b1);

    // Directed vector table
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      instr_in = tv[i].instr; pc_in = 32'h1000 + 4 * i;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tv[i].nm, "_valid"}, tv[i].nom ? n_out_valid : a_out_valid, 1'b1);
      chk(tv[i].nm, tv[i].nom ? n_ctl : a_ctl, tv[i].exp);
    end
    @(negedge clk);
    chk("tbl_drained", a_out_valid, 1'b0);

    // Stall with three offered words, then drain in order
    out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h00100093; pc_in = 32'h100;
    @(negedge clk);
    chk("stall_ready1", a_in_ready, 1'b1);
    chk("stall_pc_a", a_pc_out, 32'h100);
    instr_in = 32'h00200113; pc_in = 32'h104;
    @(negedge clk);
    chk("stall_ready2", a_in_ready, 1'b0);
    instr_in = 32'h00300193; pc_in = 32'h108;
    @(negedge clk);
    chk("stall_ready3", a_in_ready, 1'b0);
    chk("stall_hold_pc", a_pc_out, 32'h100);
    chk("stall_hold_instr", a_instr_out, 32'h00100093);
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_pc_b", a_pc_out, 32'h104);
    chk("drain_ready", a_in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_pc_c", a_pc_out, 32'h108);
    chk("drain_instr_c", a_instr_out, 32'h00300193);
    @(negedge clk);
    chk("drain_empty", a_out_valid, 1'b0);

    // Flush with head and skid full, an offer present
    out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'h00400213; pc_in = 32'h200;
    @(negedge clk);
    pc_in = 32'h204;
    @(negedge clk);
    flush = 1'b1; pc_in = 32'h208;
    @(negedge clk);
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    flush = 1'b0; out_ready = 1'b1; pc_in = 32'h20C;
    @(negedge clk);
    in_valid = 1'b0;
    chk("flush_next_valid", a_out_valid, 1'b1);
    chk("flush_next_pc", a_pc_out, 32'h20C);
    @(negedge clk);
    chk("flush_alone", a_out_valid, 1'b0);

    // Flush beats an accept when the stage has room
    out_ready = 1'b0; in_valid = 1'b1; pc_in = 32'h300;
    @(negedge clk);
    flush = 1'b1; pc_in = 32'h304;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_prio_valid", a_out_valid, 1'b0);
    chk("flush_prio_ready", a_in_ready, 1'b1);

    // Random traffic against the queue model
    q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_model();
      rst       = ($urandom_range(0, 300) == 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr_in  = gen_instr();
      pc_in     = 32'h8000 + 4 * cyc;
      if (rst || flush) begin
        q.delete();
      end else begin
        bit acc;
        acc = in_valid && (q.size() < 2);
        if ((q.size() > 0) && out_ready) void'(q.pop_front());
        if (acc) q.push_back('{instr_in, pc_in});
      end
    end
    @(negedge clk);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
